// File: rtl/adex_neuron_array.sv
// adex_neuron_array
//   Time-multiplexed AdEx neuron engine. One sweep advances every neuron by a
//   single Euler step. State (v, u) is signed Q8.8. The exponential term uses a
//   shift-based 2^x approximation, so the datapath needs no dividers.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               pulse; begins a sweep when idle
//   busy                high while a sweep is in progress
//   done                one-cycle pulse after the last neuron is written back
//   i_in                per-neuron input current, neuron n at [n*DW +: DW]
//   spike_vec           spike flags of the last completed sweep
//   wr_en, wr_addr,
//   wr_v, wr_u          host state write, honoured only while idle
//   rd_addr, rd_v, rd_u registered state readback, 1-cycle latency
module adex_neuron_array #(
  parameter int N_NEURONS     = 8,
  parameter int DW            = 16,
  parameter int E_L           = -17920,
  parameter int V_T           = -14080,
  parameter int V_PEAK        = 0,
  parameter int V_RESET       = -14848,
  parameter int B             = 1024,
  parameter int DELTA_T_SHIFT = 1,
  parameter int TAU_SHIFT     = 1,
  parameter int C_SHIFT       = 4,
  parameter int A_SHIFT       = 4,
  parameter int TAUW_SHIFT    = 3,
  parameter int DT_SHIFT      = 2,
  parameter int EXP_KMAX      = 6,
  localparam int AW           = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [N_NEURONS*DW-1:0] i_in,
  output logic [N_NEURONS-1:0]    spike_vec,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DW-1:0]           wr_v,
  input  logic [DW-1:0]           wr_u,
  input  logic [AW-1:0]           rd_addr,
  output logic [DW-1:0]           rd_v,
  output logic [DW-1:0]           rd_u
);

  // Six guard bits keep every intermediate of the update free of overflow.
  localparam int XW = DW + 6;

  typedef logic signed [XW-1:0] wide_t;
  typedef logic signed [DW-1:0] word_t;
  typedef enum logic [2:0] {IDLE, RD, EXP, UPD, WB} state_t;

  localparam wide_t EL_X    = wide_t'(E_L);
  localparam wide_t VT_X    = wide_t'(V_T);
  localparam wide_t B_X     = wide_t'(B);
  localparam wide_t SMAX_X  = wide_t'((2 ** (DW - 1)) - 1);
  localparam wide_t SMIN_X  = wide_t'(-(2 ** (DW - 1)));
  localparam wide_t EMAX_X  = wide_t'(2 ** (EXP_KMAX + 8));
  localparam word_t VPEAK_W = word_t'(V_PEAK);
  localparam word_t VRST_W  = word_t'(V_RESET);
  localparam word_t EL_W    = word_t'(E_L);

  function automatic word_t sat(input wide_t a);
    if (a > SMAX_X)      return word_t'(SMAX_X);
    else if (a < SMIN_X) return word_t'(SMIN_X);
    else                 return word_t'(a);
  endfunction

  state_t               state_q, state_d;
  logic [AW-1:0]        idx;
  logic                 last;
  word_t                v_mem [N_NEURONS];
  word_t                u_mem [N_NEURONS];
  wide_t                v_r, u_r, i_r, e_r;
  word_t                nv_r, nu_r;
  logic                 spk_r;
  logic [N_NEURONS-1:0] shadow, shadow_nx;

  assign last = (32'(idx) == N_NEURONS - 1);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = RD;
      RD:      state_d = EXP;
      EXP:     state_d = UPD;
      UPD:     state_d = WB;
      WB:      state_d = last ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  // Exponential: y ~= x*log2(e), split into integer k and fraction f, then
  // E = (1 + f/256) * 2^k in Q8.8, flushed to 0 below 2^-8 and capped at 2^KMAX.
  wide_t ex_x, ex_y, ex_k, ex_mant, ex_e;
  always_comb begin
    ex_x    = (v_r - VT_X) >>> DELTA_T_SHIFT;
    ex_y    = ex_x + (ex_x >>> 1) - (ex_x >>> 4);
    ex_k    = ex_y >>> 8;
    ex_mant = wide_t'({1'b1, ex_y[7:0]});
    if (ex_k < -8)             ex_e = '0;
    else if (ex_k >= EXP_KMAX) ex_e = EMAX_X;
    else if (ex_k >= 0)        ex_e = ex_mant << ex_k;
    else                       ex_e = ex_mant >>> (-ex_k);
  end

  // Euler step from the latched old v and u.
  wide_t dv, du;
  word_t v_new, u_new;
  always_comb begin
    dv    = ((((EL_X - v_r) + (e_r <<< DELTA_T_SHIFT)) >>> TAU_SHIFT)
             + ((i_r - u_r) >>> C_SHIFT)) >>> DT_SHIFT;
    du    = ((((v_r - EL_X) >>> A_SHIFT) - u_r) >>> TAUW_SHIFT) >>> DT_SHIFT;
    v_new = sat(v_r + dv);
    u_new = sat(u_r + du);
  end

  always_comb begin
    shadow_nx      = shadow;
    shadow_nx[idx] = spk_r;
  end

  // NOTE: sequential state is assigned with <= only, so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx       <= '0;
      done      <= 1'b0;
      spike_vec <= '0;
      shadow    <= '0;
      v_r       <= '0;
      u_r       <= '0;
      i_r       <= '0;
      e_r       <= '0;
      nv_r      <= '0;
      nu_r      <= '0;
      spk_r     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: idx <= '0;
        RD: begin
          v_r <= wide_t'(v_mem[idx]);
          u_r <= wide_t'(u_mem[idx]);
          i_r <= wide_t'($signed(i_in[32'(idx)*DW +: DW]));
        end
        EXP: e_r <= ex_e;
        UPD: begin
          if (v_new >= VPEAK_W) begin
            nv_r  <= VRST_W;
            nu_r  <= sat(wide_t'(u_new) + B_X);
            spk_r <= 1'b1;
          end else begin
            nv_r  <= v_new;
            nu_r  <= u_new;
            spk_r <= 1'b0;
          end
        end
        WB: begin
          shadow <= shadow_nx;
          if (last) begin
            spike_vec <= shadow_nx;
            done      <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the state array is reset on purpose: the rest potential is the
  // architectural starting point of every neuron, not a don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n] <= EL_W;
        u_mem[n] <= '0;
      end
      rd_v <= '0;
      rd_u <= '0;
    end else begin
      if (state_q == WB) begin
        v_mem[idx] <= nv_r;
        u_mem[idx] <= nu_r;
      end else if (wr_en && state_q == IDLE && 32'(wr_addr) < N_NEURONS) begin
        v_mem[wr_addr] <= word_t'(wr_v);
        u_mem[wr_addr] <= word_t'(wr_u);
      end
      rd_v <= (32'(rd_addr) < N_NEURONS) ? v_mem[rd_addr] : '0;
      rd_u <= (32'(rd_addr) < N_NEURONS) ? u_mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_adex_neuron_array.sv
// Self-checking bench for adex_neuron_array: directed scenarios followed by
// randomized sweeps, all compared against an integer reference model of the
// AdEx Euler step.
module tb_adex_neuron_array;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;

  localparam int E_L = -17920, V_T = -14080, V_PEAK = 0, V_RESET = -14848;
  localparam int B = 1024, KMAX = 6;
  localparam int DTS = 1, TAU = 1, CS = 4, AS = 4, TWS = 3, DTSH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [AW-1:0]   rd_addr = '0;
  logic [DW-1:0]   wr_v = '0;
  logic [DW-1:0]   wr_u = '0;
  logic [N*DW-1:0] i_in = '0;
  logic            busy, done;
  logic [N-1:0]    spike_vec;
  logic [DW-1:0]   rd_v, rd_u;

  int           n_checks = 0;
  int           n_fails  = 0;
  int           m_v [N];
  int           m_u [N];
  int           m_i [N];
  logic [N-1:0] m_spk;

  adex_neuron_array #(.N_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i_in(i_in), .spike_vec(spike_vec), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_v(wr_v), .wr_u(wr_u), .rd_addr(rd_addr), .rd_v(rd_v), .rd_u(rd_u)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input int a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  function automatic logic [15:0] w16(input int x);
    return x[15:0];
  endfunction

  function automatic void model_step(input int v, input int u, input int i,
                                     output int nv, output int nu, output logic s);
    int x, y, k, f, e, dv, du, vp, up;
    x = fdiv(v - V_T, 2 ** DTS);
    y = x + fdiv(x, 2) - fdiv(x, 16);
    k = fdiv(y, 256);
    f = y - 256 * k;
    if (k < -8)       e = 0;
    else if (k >= KMAX) e = 256 * (2 ** KMAX);
    else if (k >= 0)  e = (256 + f) * (2 ** k);
    else              e = fdiv(256 + f, 2 ** (-k));
    dv = fdiv(fdiv(E_L - v + e * (2 ** DTS), 2 ** TAU) + fdiv(i - u, 2 ** CS), 2 ** DTSH);
    du = fdiv(fdiv(fdiv(v - E_L, 2 ** AS) - u, 2 ** TWS), 2 ** DTSH);
    vp = clamp16(v + dv);
    up = clamp16(u + du);
    if (vp >= V_PEAK) begin
      nv = V_RESET; nu = clamp16(up + B); s = 1'b1;
    end else begin
      nv = vp; nu = up; s = 1'b0;
    end
  endfunction

  function automatic void model_sweep();
    for (int n = 0; n < N; n++) begin
      int nv, nu;
      logic s;
      model_step(m_v[n], m_u[n], m_i[n], nv, nu, s);
      m_v[n] = nv; m_u[n] = nu; m_spk[n] = s;
    end
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < N; n++) begin
      m_v[n] = E_L; m_u[n] = 0;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_i();
    for (int n = 0; n < N; n++) i_in[n*DW +: DW] = w16(m_i[n]);
  endtask

  task automatic write_state(input int n, input int v, input int u);
    wr_en = 1'b1; wr_addr = AW'(n); wr_v = w16(v); wr_u = w16(u);
    tick();
    wr_en = 1'b0;
    m_v[n] = v; m_u[n] = u;
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < N; n++) begin
      rd_addr = AW'(n);
      tick();
      check($sformatf("%s_v%0d", tag, n), rd_v, w16(m_v[n]));
      check($sformatf("%s_u%0d", tag, n), rd_u, w16(m_u[n]));
    end
  endtask

  // Start a sweep and wait (bounded) for done; also clears any write the
  // caller set up to coincide with start.
  task automatic run_sweep(input string tag);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4 * N);
    check({tag, "_busy_fall"}, busy, 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    model_sweep();
    check({tag, "_spikes"}, spike_vec, m_spk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, dcnt, dat;
    model_reset();
    for (int n = 0; n < N; n++) m_i[n] = 0;
    m_spk = '0;
    apply_i();

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spk", spike_vec, 0);
    check("rst_rdv", rd_v, 0);
    check("rst_rdu", rd_u, 0);
    rst = 1'b0;
    check_all("rst_state");

    // Rest: zero current leaves every neuron at E_L
    run_sweep("rest");
    check_all("rest");
    rd_addr = 3'd5; tick();
    check("rest_v5_const", rd_v, 16'hBA00);

    // Current step on neuron 3
    m_i[3] = 16384; apply_i();
    run_sweep("step");
    check_all("step");
    rd_addr = 3'd3; tick();
    check("step_v3_const", rd_v, 16'hBB00);
    check("step_u3_const", rd_u, 16'h0000);

    // Spike on neuron 0
    for (int n = 0; n < N; n++) m_i[n] = 0;
    apply_i();
    write_state(0, -1280, 0);
    run_sweep("spike");
    check("spike_vec_const", spike_vec, 8'h01);
    check_all("spike");

    // Readback latency: rd_v changes exactly one edge after rd_addr
    rd_addr = 3'd3; tick();
    rd_addr = 3'd0; #1;
    check("rdlat_hold", rd_v, w16(m_v[3]));
    tick();
    check("rdlat_v0", rd_v, 16'hC600);
    check("rdlat_u0", rd_u, 16'h0420);

    // start and wr_en mid-sweep are ignored
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0; dcnt = 0; dat = -1;
    while (cyc < 40) begin
      if (cyc == 10) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_v = 16'h1234; wr_u = 16'h5678;
      end
      tick(); cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (done) begin
        dcnt++;
        if (dat < 0) dat = cyc;
      end
    end
    check("busy_done_count", dcnt, 1);
    check("busy_done_cycle", dat, 32);
    model_sweep();
    check("busy_spikes", spike_vec, m_spk);
    check_all("busy");

    // Reset mid-sweep discards the sweep
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_spk", spike_vec, 0);
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    model_reset();
    check_all("midrst");
    run_sweep("clean");
    check_all("clean");

    // Write coincident with start: sweep uses the written value
    wr_en = 1'b1; wr_addr = 3'd2; wr_v = 16'hCE00; wr_u = 16'h0100;
    m_v[2] = -12800; m_u[2] = 256;
    run_sweep("wrstart");
    check_all("wrstart");

    // Randomized sweeps, including saturation extremes on neuron 7
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < N; n++) begin
        write_state(n, int'($urandom_range(0, 25600)) - 20480,
                       int'($urandom_range(0, 4096)) - 2048);
        m_i[n] = int'($signed(16'($urandom)));
      end
      if (r == 0) begin
        write_state(7, 32767, -32768); m_i[7] = 32767;
      end else if (r == 1) begin
        write_state(7, -32768, 32767); m_i[7] = -32768;
      end
      apply_i();
      run_sweep($sformatf("rnd%0d_a", r));
      run_sweep($sformatf("rnd%0d_b", r));
      check_all($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
